// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory arbiter controller: access mode
// encodings, FSM state type/values and the default timeout.
// Optional feature macro used by the controller: MEM_ARB_TIMEOUT_EN.
package mem_ctrl_pkg;

    localparam logic [1:0] MODE_BYTE  = 2'b00;
    localparam logic [1:0] MODE_HALF  = 2'b01;
    localparam logic [1:0] MODE_WORD  = 2'b10;
    localparam logic [1:0] MODE_DWORD = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t ACCESS  = 3'd1;
    localparam state_t GAP     = 3'd2;
    localparam state_t ACCESS2 = 3'd3;
    localparam state_t DONE    = 3'd4;

    localparam int DEF_TIMEOUT_CYCLES = 15;

    // Zero-extend a RAM read word according to the access width.
    function automatic logic [31:0] zext_rdata(input logic [1:0] mode, input logic [31:0] raw);
        case (mode)
            MODE_BYTE: return {24'h0, raw[7:0]};
            MODE_HALF: return {16'h0, raw[15:0]};
            default:   return raw;
        endcase
    endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin grant. Requester 0 = data port, 1 = fetch port.
// The pointer remembers who was granted last; after reset it points at
// fetch so the data port wins the first contention.
module mem_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    logic last_f;

    // On contention the requester not granted last wins
    always_comb begin
        gnt[0] = req[0] & (~req[1] | last_f);
        gnt[1] = req[1] & (~req[0] | ~last_f);
    end

    // Remember the winner whenever a grant is actually taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_f <= 1'b1;
        else if (take)
            last_f <= gnt[1];
    end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Memory arbiter controller: shares one 32-bit RAM port between an
// instruction fetch port and a data port. Doubleword data accesses are
// split into two word accesses separated by a one-cycle enable gap.
// Optional: define MEM_ARB_TIMEOUT_EN to abort accesses that never see
// mem_moc within TIMEOUT_CYCLES (ack with err=1, rdata 0).
module mem_arbiter_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int ADDR_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [1:0]        d_mode,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    output logic              d_ack,
    output logic [63:0]       d_rdata,
    output logic              err,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [1:0]        mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_moc
);

    state_t      state;
    logic [1:0]  gnt;
    logic        any_req;
    logic        cur_d;      // current transaction belongs to the data port
    logic        cur_dword;  // current transaction is a split doubleword
    logic [31:0] wlo;        // second-half write word for doublewords
    logic [31:0] cap_hi;     // first-half read word for doublewords
    logic        fin;        // transaction completes at this edge
    logic        fin_tmo;    // completion is due to timeout
    logic [63:0] fin_data;

    assign any_req    = if_req | d_req;
    assign mem_enable = (state == ACCESS) || (state == ACCESS2);

    mem_rr_arbiter u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({if_req, d_req}),
        .take  ((state == IDLE) && any_req),
        .gnt   (gnt)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    // Wait counter, cleared before each enable phase, saturates at the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (!mem_enable)
            cnt <= '0;
        else if (!mem_moc && cnt != CNT_W'(TIMEOUT_CYCLES))
            cnt <= cnt + 1'b1;
    end

    // Error flag accompanies the ack pulse only
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else
            err <= fin & fin_tmo;
    end
`else
    assign err = 1'b0;
`endif

    // Decide whether this edge finishes the transaction and with what data
    always_comb begin
        fin      = 1'b0;
        fin_tmo  = 1'b0;
        fin_data = '0;
        if (state == ACCESS && mem_moc && !cur_dword) begin
            fin      = 1'b1;
            fin_data = {32'h0, zext_rdata(mem_mode, mem_rdata)};
        end else if (state == ACCESS2 && mem_moc) begin
            fin      = 1'b1;
            fin_data = {cap_hi, mem_rdata};
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (mem_enable && !mem_moc && cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            fin     = 1'b1;
            fin_tmo = 1'b1;
        end
`endif
    end

    // Main FSM: grant, drive the RAM, split doublewords, pulse the ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_d     <= 1'b0;
            cur_dword <= 1'b0;
            wlo       <= '0;
            cap_hi    <= '0;
            mem_rw    <= 1'b0;
            mem_mode  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= ACCESS;
                        cur_d <= gnt[0];
                        if (gnt[0]) begin
                            cur_dword <= (d_mode == MODE_DWORD);
                            mem_rw    <= d_rw;
                            mem_mode  <= (d_mode == MODE_DWORD) ? MODE_WORD : d_mode;
                            mem_addr  <= d_addr;
                            mem_wdata <= (d_mode == MODE_DWORD) ? d_wdata[63:32] : d_wdata[31:0];
                            wlo       <= d_wdata[31:0];
                        end else begin
                            cur_dword <= 1'b0;
                            mem_rw    <= 1'b1;
                            mem_mode  <= MODE_WORD;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_moc && cur_dword) begin
                        state <= GAP;
                        if (mem_rw)
                            cap_hi <= mem_rdata;
                    end
                end
                GAP: begin
                    // Second word: address wraps naturally at ADDR_W bits
                    state     <= ACCESS2;
                    mem_addr  <= mem_addr + ADDR_W'(4);
                    mem_wdata <= wlo;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (fin) begin
                state <= DONE;
                if (cur_d) begin
                    d_ack <= 1'b1;
                    if (mem_rw || fin_tmo)
                        d_rdata <= fin_data;
                end else begin
                    if_ack   <= 1'b1;
                    if_rdata <= fin_data[31:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed testbench for mem_arbiter_ctrl: reset state, arbitration,
// fetch, doubleword split with address wrap, sub-word reads, stalled
// access (timeout when MEM_ARB_TIMEOUT_EN is defined) and mid-access reset.
module tb_mem_arbiter_ctrl;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_rw;
    logic [1:0]  d_mode;
    logic [7:0]  d_addr;
    logic [63:0] d_wdata;
    logic        d_ack;
    logic [63:0] d_rdata;
    logic        err;
    logic        mem_enable;
    logic        mem_rw;
    logic [1:0]  mem_mode;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_moc;

    logic        moc_en;
    logic [31:0] rd_val;
    int          passed = 0;
    int          total  = 0;

    // RAM stand-in: completes in the first enabled cycle when moc_en is set
    assign mem_moc   = moc_en & mem_enable;
    assign mem_rdata = rd_val;

    always #5 clk = ~clk;

    mem_arbiter_ctrl #(.TIMEOUT_CYCLES(T), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_mode(d_mode), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_mode(mem_mode),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_moc(mem_moc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_rw = 0; d_mode = 0;
        d_addr = 0; d_wdata = 0; moc_en = 1'b1; rd_val = 0;
        tick(); tick();
        chk("rst_enable", mem_enable, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_err", err, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;
        tick();

        // contention: data first after reset, then alternate
        if_req = 1; if_addr = 8'h30; d_req = 1; d_rw = 1; d_mode = 2'b10; d_addr = 8'h20;
        rd_val = 32'hCAFEF00D;
        tick();
        chk("arb1_addr", mem_addr, 8'h20);
        chk("arb1_en", mem_enable, 1);
        tick();
        chk("arb1_d_ack", d_ack, 1);
        chk("arb1_if_ack", if_ack, 0);
        chk("arb1_rdata", d_rdata, 64'hCAFEF00D);
        tick();
        chk("arb_idle_en", mem_enable, 0);
        tick();
        chk("arb2_addr", mem_addr, 8'h30);
        chk("arb2_rw", mem_rw, 1);
        tick();
        chk("arb2_if_ack", if_ack, 1);
        chk("arb2_d_ack", d_ack, 0);
        chk("arb2_rdata", if_rdata, 32'hCAFEF00D);
        tick(); tick();
        chk("arb3_addr", mem_addr, 8'h20);
        tick();
        chk("arb3_d_ack", d_ack, 1);
        if_req = 0; d_req = 0;
        tick();

        // plain fetch
        if_req = 1; if_addr = 8'h10; rd_val = 32'hDEADBEEF;
        tick();
        chk("f_en", mem_enable, 1);
        chk("f_mode", mem_mode, 2'b10);
        chk("f_rw", mem_rw, 1);
        chk("f_addr", mem_addr, 8'h10);
        chk("f_ack_early", if_ack, 0);
        tick();
        chk("f_ack", if_ack, 1);
        chk("f_rdata", if_rdata, 32'hDEADBEEF);
        chk("f_err", err, 0);
        if_req = 0;
        tick();
        chk("f_ack_pulse", if_ack, 0);
        chk("f_rdata_hold", if_rdata, 32'hDEADBEEF);
        chk("d_rdata_hold", d_rdata, 64'hCAFEF00D);

        // doubleword write wrapping past FF
        d_req = 1; d_rw = 0; d_mode = 2'b11; d_addr = 8'hFC; d_wdata = 64'h11223344_55667788;
        tick();
        chk("dw_en1", mem_enable, 1);
        chk("dw_addr1", mem_addr, 8'hFC);
        chk("dw_wdata1", mem_wdata, 32'h11223344);
        chk("dw_mode1", mem_mode, 2'b10);
        chk("dw_rw1", mem_rw, 0);
        tick();
        chk("dw_gap", mem_enable, 0);
        chk("dw_gap_ack", d_ack, 0);
        tick();
        chk("dw_en2", mem_enable, 1);
        chk("dw_addr2", mem_addr, 8'h00);
        chk("dw_wdata2", mem_wdata, 32'h55667788);
        chk("dw_mode2", mem_mode, 2'b10);
        chk("dw_ack_early", d_ack, 0);
        tick();
        chk("dw_ack", d_ack, 1);
        d_req = 0;
        tick();
        chk("dw_ack_pulse", d_ack, 0);

        // byte read
        d_req = 1; d_rw = 1; d_mode = 2'b00; d_addr = 8'h05; rd_val = 32'h000000A5;
        tick();
        chk("b_mode", mem_mode, 2'b00);
        chk("b_addr", mem_addr, 8'h05);
        tick();
        chk("b_ack", d_ack, 1);
        chk("b_rdata", d_rdata, 64'h00000000_000000A5);
        d_req = 0;
        tick();

        // half read, request dropped after grant
        d_req = 1; d_mode = 2'b01; d_addr = 8'h40; rd_val = 32'hABCD1234;
        tick();
        d_req = 0;
        chk("h_mode", mem_mode, 2'b01);
        tick();
        chk("h_ack", d_ack, 1);
        chk("h_rdata", d_rdata, 64'h1234);
        tick();

        // doubleword read
        d_req = 1; d_mode = 2'b11; d_addr = 8'h80; rd_val = 32'hAAAA0001;
        tick();
        chk("dr_addr1", mem_addr, 8'h80);
        tick();
        rd_val = 32'hBBBB0002;
        tick();
        chk("dr_addr2", mem_addr, 8'h84);
        tick();
        chk("dr_ack", d_ack, 1);
        chk("dr_rdata", d_rdata, 64'hAAAA0001_BBBB0002);
        d_req = 0;
        tick();

        // RAM never completes
        moc_en = 0; d_req = 1; d_rw = 1; d_mode = 2'b10; d_addr = 8'h33;
        repeat (T + 1) tick();
        chk("st_ack_early", d_ack, 0);
        chk("st_en", mem_enable, 1);
        tick();
`ifdef MEM_ARB_TIMEOUT_EN
        chk("to_ack", d_ack, 1);
        chk("to_err", err, 1);
        chk("to_rdata", d_rdata, 0);
        d_req = 0;
        tick();
        chk("to_err_pulse", err, 0);
        d_req = 1;
        tick();
`else
        chk("st_no_ack", d_ack, 0);
        chk("st_still_en", mem_enable, 1);
        chk("st_no_err", err, 0);
`endif

        // reset in the middle of an access
        reset = 1; d_req = 0;
        #1;
        chk("rr_en_drop", mem_enable, 0);
        chk("rr_no_ack", d_ack, 0);
        tick();
        chk("rr_d_rdata", d_rdata, 0);
        chk("rr_if_rdata", if_rdata, 0);
        reset = 0; moc_en = 1;
        tick();
        chk("rr_no_ack_after", d_ack, 0);

        if_req = 1; if_addr = 8'h44; rd_val = 32'h12345678;
        tick();
        chk("rr_f_addr", mem_addr, 8'h44);
        chk("rr_f_en", mem_enable, 1);
        tick();
        chk("rr_f_ack", if_ack, 1);
        chk("rr_f_rdata", if_rdata, 32'h12345678);
        if_req = 0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
